// File: rtl/uart_cfg.sv
// uart_cfg: parametrised full-duplex UART with configurable data width,
// parity (none/even/odd) and one or two stop bits.
//
// Parameters:
//   CLK_FREQ_MHZ, BAUD : DIVIDER = CLK_FREQ_MHZ*1e6/BAUD clocks per bit (>= 4)
//   DATA_BITS          : payload width, 5..9
//   PARITY             : 0 none, 1 even, 2 odd
//   STOP_BITS          : 1 or 2
//
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   tx                  : serial output, idle high
//   tx_data, tx_start   : payload and level send request
//   tx_busy             : transmit frame in progress
//   tx_clkpulse         : one-cycle strobe at mid-bit of every transmitted bit
//   rx                  : asynchronous serial input
//   rx_data, rx_valid   : last received payload, one-cycle completion strobe
//   rx_busy             : receiver inside a frame
//   rx_parity_err       : parity mismatch on last frame
//   rx_frame_err        : a stop bit sampled low on last frame
//
// Handshake: tx_start is a level request. While the transmitter is idle, a
// high tx_start at a clock edge accepts a frame and latches tx_data; tx_busy
// stays high for the whole frame and neither input is looked at again until
// the transmitter is back in idle. There is no backpressure on the receive
// side: rx_valid is a single-cycle strobe and rx_data/error flags hold until
// the next strobe.
module uart_cfg #(
  parameter int CLK_FREQ_MHZ = 12,
  parameter int BAUD         = 1200000,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx_clkpulse,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int DIVIDER = CLK_FREQ_MHZ * 1000000 / BAUD;
  localparam int CW      = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int IW      = 4;

  localparam logic [CW-1:0] CNT_LAST    = CW'(DIVIDER - 1);
  localparam logic [CW-1:0] CNT_MID     = CW'(DIVIDER / 2);
  localparam logic [CW-1:0] CNT_HALF_M1 = CW'(DIVIDER / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE       = IW'(1);

  localparam logic HAS_PAR = (PARITY != 0);
  localparam logic ODD     = (PARITY == 2);

  generate
    if (DIVIDER < 4) begin : g_bad_divider
      $error("uart_cfg: DIVIDER must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------- transmit
  state_t                 tx_state, tx_state_n;
  logic [CW-1:0]          tx_cnt, tx_cnt_n;
  logic [IW-1:0]          tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0]   tx_sh, tx_sh_n;
  logic                   tx_par, tx_par_n;
  logic                   tx_bit_end;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    tx_bit_end = (tx_cnt == CNT_LAST);

    if (tx_state != S_IDLE) begin
      tx_cnt_n = tx_bit_end ? '0 : tx_cnt + CNT_ONE;
    end

    case (tx_state)
      S_IDLE: begin
        if (tx_start) begin
          tx_state_n = S_START;
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_sh_n    = tx_data;
          tx_par_n   = (^tx_data) ^ ODD;
        end
      end
      S_START: begin
        if (tx_bit_end) begin
          tx_state_n = S_DATA;
          tx_idx_n   = '0;
        end
      end
      S_DATA: begin
        if (tx_bit_end) begin
          // The line always shows tx_sh[0]; shift to present the next bit.
          tx_sh_n = tx_sh >> 1;
          if (tx_idx == IDX_DATA_LAST) begin
            tx_state_n = HAS_PAR ? S_PARITY : S_STOP;
            tx_idx_n   = '0;
          end else begin
            tx_idx_n = tx_idx + IDX_ONE;
          end
        end
      end
      S_PARITY: begin
        if (tx_bit_end) begin
          tx_state_n = S_STOP;
          tx_idx_n   = '0;
        end
      end
      S_STOP: begin
        if (tx_bit_end) begin
          if (tx_idx == IDX_STOP_LAST) begin
            tx_state_n = S_IDLE;
            tx_idx_n   = '0;
          end else begin
            tx_idx_n = tx_idx + IDX_ONE;
          end
        end
      end
      default: begin
        tx_state_n = S_IDLE;
        tx_cnt_n   = '0;
        tx_idx_n   = '0;
      end
    endcase
  end

  always_comb begin
    case (tx_state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = tx_sh[0];
      S_PARITY: tx = tx_par;
      default:  tx = 1'b1;
    endcase
  end

  assign tx_busy     = (tx_state != S_IDLE);
  assign tx_clkpulse = (tx_state != S_IDLE) && (tx_cnt == CNT_MID);

  // ----------------------------------------------------------------- receive
  logic [1:0]             rx_sync;
  logic                   rx_s;
  state_t                 rx_state, rx_state_n;
  logic [CW-1:0]          rx_cnt, rx_cnt_n;
  logic [IW-1:0]          rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0]   rx_sh, rx_sh_n;
  logic                   rx_par_bad, rx_par_bad_n;
  logic                   rx_stop_bad, rx_stop_bad_n;
  logic [DATA_BITS-1:0]   rx_data_n;
  logic                   rx_valid_n, rx_parity_err_n, rx_frame_err_n;
  logic                   rx_sample;

  // Synchroniser resets to the idle line level so reset never looks like a
  // start bit.
  always_ff @(posedge clk) begin
    if (!rst) rx_sync <= 2'b11;
    else      rx_sync <= {rx_sync[0], rx};
  end
  assign rx_s = rx_sync[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state      <= S_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_sh         <= '0;
      rx_par_bad    <= 1'b0;
      rx_stop_bad   <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_state      <= rx_state_n;
      rx_cnt        <= rx_cnt_n;
      rx_idx        <= rx_idx_n;
      rx_sh         <= rx_sh_n;
      rx_par_bad    <= rx_par_bad_n;
      rx_stop_bad   <= rx_stop_bad_n;
      rx_data       <= rx_data_n;
      rx_valid      <= rx_valid_n;
      rx_parity_err <= rx_parity_err_n;
      rx_frame_err  <= rx_frame_err_n;
    end
  end

  always_comb begin
    rx_state_n      = rx_state;
    rx_cnt_n        = rx_cnt;
    rx_idx_n        = rx_idx;
    rx_sh_n         = rx_sh;
    rx_par_bad_n    = rx_par_bad;
    rx_stop_bad_n   = rx_stop_bad;
    rx_data_n       = rx_data;
    rx_valid_n      = 1'b0;
    rx_parity_err_n = rx_parity_err;
    rx_frame_err_n  = rx_frame_err;
    // After the start bit is confirmed at its middle, the counter restarts
    // so every later sample lands one full bit period later: mid-bit.
    rx_sample       = (rx_cnt == CNT_LAST);

    if (rx_state != S_IDLE && rx_state != S_START) begin
      rx_cnt_n = rx_sample ? '0 : rx_cnt + CNT_ONE;
    end

    case (rx_state)
      S_IDLE: begin
        if (!rx_s) begin
          rx_state_n = S_START;
          rx_cnt_n   = '0;
        end
      end
      S_START: begin
        if (rx_cnt == CNT_HALF_M1) begin
          rx_cnt_n = '0;
          if (rx_s) begin
            // Line back high at mid start bit: a glitch, not a frame.
            rx_state_n = S_IDLE;
          end else begin
            rx_state_n    = S_DATA;
            rx_idx_n      = '0;
            rx_par_bad_n  = 1'b0;
            rx_stop_bad_n = 1'b0;
          end
        end else begin
          rx_cnt_n = rx_cnt + CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_sample) begin
          // LSB arrives first; shifting in at the top leaves it at bit 0.
          rx_sh_n = {rx_s, rx_sh[DATA_BITS-1:1]};
          if (rx_idx == IDX_DATA_LAST) begin
            rx_state_n = HAS_PAR ? S_PARITY : S_STOP;
            rx_idx_n   = '0;
          end else begin
            rx_idx_n = rx_idx + IDX_ONE;
          end
        end
      end
      S_PARITY: begin
        if (rx_sample) begin
          rx_par_bad_n = (^rx_sh) ^ rx_s ^ ODD;
          rx_state_n   = S_STOP;
          rx_idx_n     = '0;
        end
      end
      S_STOP: begin
        if (rx_sample) begin
          if (rx_idx == IDX_STOP_LAST) begin
            rx_state_n      = S_IDLE;
            rx_idx_n        = '0;
            rx_valid_n      = 1'b1;
            rx_data_n       = rx_sh;
            rx_parity_err_n = rx_par_bad;
            rx_frame_err_n  = rx_stop_bad | ~rx_s;
          end else begin
            rx_stop_bad_n = rx_stop_bad | ~rx_s;
            rx_idx_n      = rx_idx + IDX_ONE;
          end
        end
      end
      default: begin
        rx_state_n = S_IDLE;
        rx_cnt_n   = '0;
        rx_idx_n   = '0;
      end
    endcase
  end

  assign rx_busy = (rx_state != S_IDLE);

endmodule

// File: tb/tb_uart_cfg.sv
module tb_uart_cfg;
  localparam int DIV = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance 0: defaults, rx either looped from tx or driven by the bench.
  logic       tx0, tx_start0, tx_busy0, tx_clkpulse0, rx0, rx_drv0, lb0;
  logic       rx_valid0, rx_busy0, rx_perr0, rx_ferr0;
  logic [7:0] tx_data0, rx_data0;
  assign rx0 = lb0 ? tx0 : rx_drv0;

  // Instance 1: 7 data bits, even parity, 2 stop bits, looped back.
  logic       tx1, tx_start1, tx_busy1, tx_clkpulse1;
  logic       rx_valid1, rx_busy1, rx_perr1, rx_ferr1;
  logic [6:0] tx_data1, rx_data1;

  // Instance 2: odd parity, rx driven by the bench.
  logic       tx2, tx_busy2, tx_clkpulse2, rx2;
  logic       rx_valid2, rx_busy2, rx_perr2, rx_ferr2;
  logic       tx_start2;
  logic [7:0] tx_data2, rx_data2;

  uart_cfg u0 (
    .clk(clk), .rst(rst), .tx(tx0), .tx_data(tx_data0), .tx_start(tx_start0),
    .tx_busy(tx_busy0), .tx_clkpulse(tx_clkpulse0), .rx(rx0), .rx_data(rx_data0),
    .rx_valid(rx_valid0), .rx_busy(rx_busy0), .rx_parity_err(rx_perr0),
    .rx_frame_err(rx_ferr0)
  );

  uart_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .tx(tx1), .tx_data(tx_data1), .tx_start(tx_start1),
    .tx_busy(tx_busy1), .tx_clkpulse(tx_clkpulse1), .rx(tx1), .rx_data(rx_data1),
    .rx_valid(rx_valid1), .rx_busy(rx_busy1), .rx_parity_err(rx_perr1),
    .rx_frame_err(rx_ferr1)
  );

  uart_cfg #(.PARITY(2)) u2 (
    .clk(clk), .rst(rst), .tx(tx2), .tx_data(tx_data2), .tx_start(tx_start2),
    .tx_busy(tx_busy2), .tx_clkpulse(tx_clkpulse2), .rx(rx2), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .rx_busy(rx_busy2), .rx_parity_err(rx_perr2),
    .rx_frame_err(rx_ferr2)
  );

  int errors = 0;
  int checks = 0;

  // rx_valid strobe counters, sampled away from the active edge.
  int rv0_cnt = 0;
  int rv1_cnt = 0;
  int rv2_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid0 === 1'b1) rv0_cnt++;
    if (rx_valid1 === 1'b1) rv1_cnt++;
    if (rx_valid2 === 1'b1) rv2_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive n bits (LSB first) onto a bench-driven rx line, DIV clocks each.
  task automatic drive_bits(input int sel, input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rx_drv0 = bits[i];
      else          rx2     = bits[i];
      repeat (DIV) tick;
    end
    if (sel == 0) rx_drv0 = 1'b1;
    else          rx2     = 1'b1;
  endtask

  // One-cycle tx_start on instance 0 (looped back), checks the line, busy
  // length, strobes and the received copy.
  task automatic tx_frame0(input string tag, input logic [7:0] d, input logic [9:0] exp_bits);
    int mism, busy_n, pulse_n, pulse_pos, base;
    mism = 0; busy_n = 0; pulse_n = 0; pulse_pos = 0;
    base = rv0_cnt;
    tx_data0  = d;
    tx_start0 = 1'b1;
    tick;
    tx_start0 = 1'b0;
    for (int c = 0; c < 110; c++) begin
      if (c < 100) begin
        if (tx0 !== exp_bits[c / 10]) mism++;
      end else if (tx0 !== 1'b1) begin
        mism++;
      end
      if (tx_busy0 === 1'b1) busy_n++;
      if (tx_clkpulse0 === 1'b1) begin
        pulse_n++;
        if (c % 10 != 5) pulse_pos++;
      end
      tick;
    end
    check({tag, "_tx_bits"}, mism, 0);
    check({tag, "_busy_cycles"}, busy_n, 100);
    check({tag, "_pulses"}, pulse_n, 10);
    check({tag, "_pulse_pos"}, pulse_pos, 0);
    check({tag, "_rx_valids"}, rv0_cnt - base, 1);
    check({tag, "_rx_data"}, rx_data0, d);
    check({tag, "_rx_perr"}, rx_perr0, 0);
    check({tag, "_rx_ferr"}, rx_ferr0, 0);
  endtask

  initial begin
    int mism, gap_low, idle_bad, busy_n, base, saw;
    logic [9:0]  fa5;
    logic [10:0] f55;

    rst = 1'b0;
    tx_start0 = 1'b0; tx_data0 = '0; lb0 = 1'b1; rx_drv0 = 1'b1;
    tx_start1 = 1'b0; tx_data1 = '0;
    tx_start2 = 1'b0; tx_data2 = '0; rx2 = 1'b1;
    repeat (3) tick;
    rst = 1'b1;

    // Reset values
    check("rst_tx", tx0, 1);
    check("rst_tx_busy", tx_busy0, 0);
    check("rst_tx_clkpulse", tx_clkpulse0, 0);
    check("rst_rx_data", rx_data0, 0);
    check("rst_rx_valid", rx_valid0, 0);
    check("rst_rx_busy", rx_busy0, 0);
    check("rst_rx_perr", rx_perr0, 0);
    check("rst_rx_ferr", rx_ferr0, 0);
    check("rst_tx1", tx1, 1);
    check("rst_tx2", tx2, 1);
    repeat (5) tick;

    // 8'h61: line sequence 0,1,0,0,0,0,1,1,0,1
    tx_frame0("f61", 8'h61, 10'b10_1100_0010);

    // Three back-to-back frames of 8'hA5, tx_start dropped in frame 3
    fa5 = 10'b11_0100_1010;
    mism = 0; gap_low = 0; idle_bad = 0;
    base = rv0_cnt;
    tx_data0  = 8'hA5;
    tx_start0 = 1'b1;
    tick;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 100; c++) begin
        if (tx0 !== fa5[c / 10] || tx_busy0 !== 1'b1) mism++;
        if (k == 2 && c == 50) tx_start0 = 1'b0;
        tick;
      end
      if (tx_busy0 === 1'b0) gap_low++;
      if (k < 2) tick;
    end
    for (int c = 0; c < 20; c++) begin
      if (tx0 !== 1'b1 || tx_busy0 !== 1'b0) idle_bad++;
      tick;
    end
    check("b2b_frames", mism, 0);
    check("b2b_gaps", gap_low, 3);
    check("b2b_idle_after", idle_bad, 0);
    check("b2b_rx_valids", rv0_cnt - base, 3);
    check("b2b_rx_data", rx_data0, 8'hA5);

    // Loopback, 7 data bits, even parity, 2 stop bits, data 7'h55.
    // Bits LSB first: start 0, 1010101, parity 0, stop 1, stop 1.
    f55 = 11'b11_0_1010101_0;
    mism = 0; busy_n = 0;
    base = rv1_cnt;
    tx_data1  = 7'h55;
    tx_start1 = 1'b1;
    tick;
    tx_start1 = 1'b0;
    for (int c = 0; c < 140; c++) begin
      if (c < 110 && tx1 !== f55[c / 10]) mism++;
      if (tx_busy1 === 1'b1) busy_n++;
      tick;
    end
    check("lb7_tx_bits", mism, 0);
    check("lb7_busy_cycles", busy_n, 110);
    check("lb7_rx_valids", rv1_cnt - base, 1);
    check("lb7_rx_data", rx_data1, 7'h55);
    check("lb7_rx_perr", rx_perr1, 0);
    check("lb7_rx_ferr", rx_ferr1, 0);

    // Odd parity: 8'h3C has four ones, correct parity bit 1; send 0.
    base = rv2_cnt;
    drive_bits(1, {1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
    repeat (20) tick;
    check("par_rx_valids", rv2_cnt - base, 1);
    check("par_rx_data", rx_data2, 8'h3C);
    check("par_rx_perr", rx_perr2, 1);
    check("par_rx_ferr", rx_ferr2, 0);
    // 8'h81 with correct odd parity bit 1, stop bit 0.
    base = rv2_cnt;
    drive_bits(1, {1'b0, 1'b0, 1'b1, 8'h81, 1'b0}, 11);
    repeat (20) tick;
    check("frm_rx_valids", rv2_cnt - base, 1);
    check("frm_rx_data", rx_data2, 8'h81);
    check("frm_rx_perr", rx_perr2, 0);
    check("frm_rx_ferr", rx_ferr2, 1);

    // 3-cycle glitch on rx, then a good frame of 8'h96
    lb0 = 1'b0;
    rx_drv0 = 1'b1;
    repeat (5) tick;
    base = rv0_cnt;
    saw = 0;
    rx_drv0 = 1'b0;
    repeat (3) tick;
    rx_drv0 = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (rx_busy0 === 1'b1) saw = 1;
      tick;
    end
    check("glitch_busy_seen", saw, 1);
    check("glitch_busy_clear", rx_busy0, 0);
    check("glitch_no_valid", rv0_cnt - base, 0);
    drive_bits(0, {2'b00, 1'b1, 8'h96, 1'b0}, 10);
    repeat (20) tick;
    check("post_glitch_valids", rv0_cnt - base, 1);
    check("post_glitch_data", rx_data0, 8'h96);
    check("post_glitch_ferr", rx_ferr0, 0);
    repeat (120) tick;

    // Reset during data bit 3 of a looped-back frame
    lb0 = 1'b1;
    repeat (5) tick;
    base = rv0_cnt;
    tx_data0  = 8'h3A;
    tx_start0 = 1'b1;
    tick;
    tx_start0 = 1'b0;
    repeat (45) tick;
    check("mid_tx_busy", tx_busy0, 1);
    check("mid_rx_busy", rx_busy0, 1);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    check("mrst_tx", tx0, 1);
    check("mrst_tx_busy", tx_busy0, 0);
    check("mrst_tx_clkpulse", tx_clkpulse0, 0);
    check("mrst_rx_data", rx_data0, 0);
    check("mrst_rx_valid", rx_valid0, 0);
    check("mrst_rx_busy", rx_busy0, 0);
    check("mrst_rx_perr", rx_perr0, 0);
    check("mrst_rx_ferr", rx_ferr0, 0);
    check("mrst_rx_data1", rx_data1, 0);
    check("mrst_rx_data2", rx_data2, 0);
    check("mrst_rx_ferr2", rx_ferr2, 0);
    repeat (150) tick;
    check("mrst_no_valid", rv0_cnt - base, 0);
    check("mrst_tx_idle", tx0, 1);

    tx_frame0("f5a", 8'h5A, {1'b1, 8'h5A, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
